// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencing operands through an external full-adder stage.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout_out,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0] cnt;
    logic cr, cout_r, accept, last;
    assign accept    = state == IDLE && in_valid;
    assign last      = state == SHIFT && cnt == CW'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign fa_a      = sa[0];
    assign fa_b      = sb[0];
    assign fa_c      = cr;
    assign result    = res;
    assign cout_out  = cout_r;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = accept ? SHIFT :
                   last ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end
    // cnt saturates on the final bit so it never wraps for power-of-two widths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cr     <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            sa  <= op_a;
            sb  <= op_b;
            cr  <= cin;
            cnt <= '0;
            res <= '0;
        end else if (state == SHIFT) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            res    <= {fa_sum, res[WIDTH-1:1]};
            cr     <= fa_cout;
            cnt    <= last ? cnt : cnt + CW'(1);
            cout_r <= last ? fa_cout : cout_r;
        end
    end
endmodule
